// File: rtl/mcp3008_responder_if.sv
// rtl/mcp3008_responder_if.sv - SPI bit-stream bundle between ADC master and responder
interface mcp3008_responder_if;
  logic cs;
  logic din;
  logic dout;

  modport master (output cs, output din, input dout);
  modport slave (input cs, input din, output dout);
endinterface

// File: rtl/mcp3008_responder.sv
// rtl/mcp3008_responder.sv - MCP3008 ADC responder model, one bit per clk
// Decodes start/SGL/D2..D0, then returns null bit, B9..B0 and an optional LSB-first tail.
module mcp3008_responder #(
  parameter int SAMPLE_CYCLES = 1,
  parameter bit LSB_TAIL      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  mcp3008_responder_if.slave spi,
  input  logic [79:0]        ch_data,
  output logic               busy,
  output logic [2:0]         sel_ch,
  output logic               sgl,
  output logic               conv_done,
  output logic               frame_err
);

  typedef enum logic [2:0] {IDLE, CFG, SAMPLE, NULL, MSB, TAIL, DONE} state_t;

  state_t      state;
  logic [2:0]  cfg_q;
  logic [1:0]  cfg_cnt;
  logic [3:0]  samp_cnt;
  logic [3:0]  bit_idx;
  logic [9:0]  shift_q;

  logic [9:0]  ch [8];
  logic [9:0]  ch_pos;
  logic [9:0]  ch_neg;
  logic [10:0] diff;
  logic [9:0]  result;

  // sel_ch/sgl are already updated at T4, so they steer the latch edge directly.
  always_comb begin
    for (int i = 0; i < 8; i++) ch[i] = ch_data[10*i +: 10];
    ch_pos = ch[sel_ch];
    ch_neg = ch[{sel_ch[2:1], ~sel_ch[0]}];
    diff   = {1'b0, ch_pos} - {1'b0, ch_neg};
    if (sgl)
      result = ch_pos;
    else
      result = diff[10] ? 10'd0 : diff[9:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      spi.dout  <= 1'b1;
      busy      <= 1'b0;
      sel_ch    <= 3'd0;
      sgl       <= 1'b0;
      conv_done <= 1'b0;
      frame_err <= 1'b0;
      shift_q   <= 10'd0;
      cfg_q     <= 3'd0;
      cfg_cnt   <= 2'd0;
      samp_cnt  <= 4'd0;
      bit_idx   <= 4'd0;
    end else begin
      conv_done <= 1'b0;
      frame_err <= 1'b0;
      if (state != IDLE && spi.cs) begin
        state     <= IDLE;
        spi.dout  <= 1'b1;
        busy      <= 1'b0;
        frame_err <= state inside {CFG, SAMPLE, NULL, MSB};
      end else begin
        case (state)
          IDLE: begin
            spi.dout <= 1'b1;
            if (!spi.cs && spi.din) begin
              state   <= CFG;
              busy    <= 1'b1;
              cfg_cnt <= 2'd0;
            end
          end
          CFG: begin
            spi.dout <= 1'b1;
            cfg_cnt  <= cfg_cnt + 2'd1;
            if (cfg_cnt == 2'd3) begin
              sgl      <= cfg_q[2];
              sel_ch   <= {cfg_q[1:0], spi.din};
              samp_cnt <= 4'(SAMPLE_CYCLES - 1);
              state    <= SAMPLE;
            end else begin
              cfg_q <= {cfg_q[1:0], spi.din};
            end
          end
          SAMPLE: begin
            if (samp_cnt == 4'd0) begin
              shift_q  <= result;
              spi.dout <= 1'b0;
              state    <= NULL;
            end else begin
              spi.dout <= 1'b1;
              samp_cnt <= samp_cnt - 4'd1;
            end
          end
          NULL: begin
            spi.dout <= shift_q[9];
            bit_idx  <= 4'd8;
            state    <= MSB;
          end
          MSB: begin
            spi.dout <= shift_q[bit_idx];
            if (bit_idx == 4'd0) begin
              conv_done <= 1'b1;
              bit_idx   <= 4'd1;
              state     <= LSB_TAIL ? TAIL : DONE;
            end else begin
              bit_idx <= bit_idx - 4'd1;
            end
          end
          TAIL: begin
            spi.dout <= shift_q[bit_idx];
            if (bit_idx == 4'd9)
              state <= DONE;
            else
              bit_idx <= bit_idx + 4'd1;
          end
          default: spi.dout <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3008_responder.sv
// tb/tb_mcp3008_responder.sv - randomized self-checking bench for mcp3008_responder
module tb_mcp3008_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [79:0] ch_data = '0;
  logic        busy, sgl, conv_done, frame_err;
  logic [2:0]  sel_ch;

  mcp3008_responder_if spi();

  mcp3008_responder dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spi),
    .ch_data   (ch_data),
    .busy      (busy),
    .sel_ch    (sel_ch),
    .sgl       (sgl),
    .conv_done (conv_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int chv [8];
  bit [2:0] exp_sel = 3'd0;
  bit exp_sgl = 1'b0;

  bit cap_dout [$];
  bit cap_conv [$];
  bit cap_err [$];
  bit cap_busy [$];
  bit lead_dout [$];
  bit lead_busy [$];

  // Reference: the conversion value a real MCP3008 would report.
  function automatic int ref_result(bit s, bit [2:0] d);
    int p, m;
    if (s) return chv[d];
    p = chv[{d[2:1], d[0]}];
    m = chv[{d[2:1], ~d[0]}];
    return (p > m) ? p - m : 0;
  endfunction

  // Expected dout after edge Tn for a frame whose cs goes high at edge T(L+1).
  function automatic bit exp_dout(int n, int r, int l);
    if (n == l + 1) return 1'b1;
    if (n <= 4) return 1'b1;
    if (n == 5) return 1'b0;
    if (n <= 15) return r[15-n];
    if (n <= 24) return r[n-15];
    return 1'b0;
  endfunction

  task automatic set_ch();
    for (int i = 0; i < 8; i++) ch_data[10*i +: 10] = 10'(chv[i]);
  endtask

  task automatic run_frame(input bit s, input bit [2:0] d, input int lead, input int l);
    bit cfg [5];
    cfg[0] = 1'b1; cfg[1] = s; cfg[2] = d[2]; cfg[3] = d[1]; cfg[4] = d[0];
    cap_dout.delete(); cap_conv.delete(); cap_err.delete(); cap_busy.delete();
    lead_dout.delete(); lead_busy.delete();
    for (int i = 0; i < lead; i++) begin
      spi.cs = 1'b0; spi.din = 1'b0;
      @(negedge clk);
      lead_dout.push_back(spi.dout);
      lead_busy.push_back(busy);
    end
    for (int n = 0; n <= l + 1; n++) begin
      spi.cs  = (n == l + 1);
      spi.din = (n < 5 && n <= l) ? cfg[n] : 1'($urandom_range(0, 1));
      if (n == 7) ch_data = {16'($urandom), $urandom, $urandom};
      @(negedge clk);
      cap_dout.push_back(spi.dout);
      cap_conv.push_back(conv_done);
      cap_err.push_back(frame_err);
      cap_busy.push_back(busy);
    end
    spi.cs = 1'b1; spi.din = 1'b0;
    if (l >= 4) begin exp_sel = d; exp_sgl = s; end
  endtask

  task automatic test_reset();
    vecs++; if (spi.dout !== 1'b1) begin errs++; $display("FAIL reset_dout got %b exp 1", spi.dout); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
    vecs++; if (sel_ch !== 3'd0) begin errs++; $display("FAIL reset_sel got %0d exp 0", sel_ch); end
    vecs++; if (sgl !== 1'b0) begin errs++; $display("FAIL reset_sgl got %b exp 0", sgl); end
    vecs++; if (conv_done !== 1'b0) begin errs++; $display("FAIL reset_conv got %b exp 0", conv_done); end
    vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_err got %b exp 0", frame_err); end
  endtask

  task automatic test_fixed_frames();
    // sgl, d, channel to load, value, lead zeros, cs-low edges after T0
    bit       t_s   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit [2:0] t_d   [6] = '{3'd0, 3'd5, 3'd0, 3'd1, 3'd0, 3'd0};
    int       t_lead[6] = '{0, 0, 0, 0, 3, 0};
    int       t_l   [6] = '{16, 30, 16, 16, 16, 15};
    int r;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) chv[i] = 0;
      if (t == 0 || t == 4 || t == 5) chv[0] = 'h2A5;
      if (t == 1) chv[5] = 'h3FF;
      if (t == 2 || t == 3) begin chv[0] = 'h100; chv[1] = 'h040; end
      set_ch();
      r = ref_result(t_s[t], t_d[t]);
      run_frame(t_s[t], t_d[t], t_lead[t], t_l[t]);
      for (int i = 0; i < t_lead[t]; i++) begin
        vecs++; if (lead_dout[i] !== 1'b1 || lead_busy[i] !== 1'b0) begin
          errs++; $display("FAIL fixed%0d_lead[%0d] dout/busy got %b/%b exp 1/0", t, i, lead_dout[i], lead_busy[i]);
        end
      end
      for (int n = 0; n <= t_l[t] + 1; n++) begin
        vecs++; if (cap_dout[n] !== exp_dout(n, r, t_l[t])) begin
          errs++; $display("FAIL fixed%0d_dout[T%0d] got %b exp %b", t, n, cap_dout[n], exp_dout(n, r, t_l[t]));
        end
        vecs++; if (cap_conv[n] !== (n == 15)) begin
          errs++; $display("FAIL fixed%0d_conv[T%0d] got %b exp %b", t, n, cap_conv[n], n == 15);
        end
        vecs++; if (cap_err[n] !== 1'b0) begin
          errs++; $display("FAIL fixed%0d_err[T%0d] got %b exp 0", t, n, cap_err[n]);
        end
        vecs++; if (cap_busy[n] !== (n <= t_l[t])) begin
          errs++; $display("FAIL fixed%0d_busy[T%0d] got %b exp %b", t, n, cap_busy[n], n <= t_l[t]);
        end
      end
      vecs++; if (sel_ch !== t_d[t] || sgl !== t_s[t]) begin
        errs++; $display("FAIL fixed%0d_cfg sel/sgl got %0d/%b exp %0d/%b", t, sel_ch, sgl, t_d[t], t_s[t]);
      end
    end
  endtask

  task automatic test_cs_priority();
    spi.cs = 1'b1; spi.din = 1'b1;
    @(negedge clk);
    spi.cs = 1'b0; spi.din = 1'b0;
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || spi.dout !== 1'b1) begin
      errs++; $display("FAIL cs_priority busy/dout got %b/%b exp 0/1", busy, spi.dout);
    end
    spi.cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) chv[i] = $urandom_range(0, 1023);
    set_ch();
    run_frame(1'b1, 3'd3, 0, 10);
    // Redo with reset instead of cs: restart the frame and pull rst after T10.
    spi.cs = 1'b0; spi.din = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      spi.din = (n == 0 || n == 1) ? 1'b1 : 1'b0;
    end
    rst = 1'b0;
    #1;
    vecs++; if (spi.dout !== 1'b1 || busy !== 1'b0 || sel_ch !== 3'd0 || sgl !== 1'b0) begin
      errs++; $display("FAIL midrst_outputs dout/busy/sel/sgl got %b/%b/%0d/%b exp 1/0/0/0", spi.dout, busy, sel_ch, sgl);
    end
    spi.cs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++; if (conv_done !== 1'b0 || frame_err !== 1'b0) begin
        errs++; $display("FAIL midrst_pulse[%0d] conv/err got %b/%b exp 0/0", i, conv_done, frame_err);
      end
    end
    rst = 1'b1;
    exp_sel = 3'd0; exp_sgl = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) chv[i] = 0;
    chv[2] = 'h155;
    set_ch();
    run_frame(1'b1, 3'd2, 0, 30);
    for (int n = 0; n <= 31; n++) begin
      vecs++; if (cap_dout[n] !== exp_dout(n, 'h155, 30)) begin
        errs++; $display("FAIL midrst_dout[T%0d] got %b exp %b", n, cap_dout[n], exp_dout(n, 'h155, 30));
      end
      vecs++; if (cap_conv[n] !== (n == 15) || cap_err[n] !== 1'b0) begin
        errs++; $display("FAIL midrst_pulse[T%0d] conv/err got %b/%b exp %b/0", n, cap_conv[n], cap_err[n], n == 15);
      end
    end
  endtask

  // Random frames back to back, including early cs aborts; checks the frame after each abort too.
  task automatic test_random();
    bit s;
    bit [2:0] d;
    int l, r;
    bit e;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 8; i++) chv[i] = $urandom_range(0, 1023);
      set_ch();
      s = 1'($urandom_range(0, 1));
      d = 3'($urandom_range(0, 7));
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(16, 30);
      if (f == 0) l = 8;
      r = ref_result(s, d);
      run_frame(s, d, 0, l);
      for (int n = 0; n <= l + 1; n++) begin
        e = (n == l + 1) && (n <= 15);
        vecs++; if (cap_dout[n] !== exp_dout(n, r, l)) begin
          errs++; $display("FAIL rand%0d_dout[T%0d] got %b exp %b (L=%0d)", f, n, cap_dout[n], exp_dout(n, r, l), l);
        end
        vecs++; if (cap_conv[n] !== (n == 15 && l >= 15)) begin
          errs++; $display("FAIL rand%0d_conv[T%0d] got %b exp %b (L=%0d)", f, n, cap_conv[n], n == 15 && l >= 15, l);
        end
        vecs++; if (cap_err[n] !== e) begin
          errs++; $display("FAIL rand%0d_err[T%0d] got %b exp %b (L=%0d)", f, n, cap_err[n], e, l);
        end
        vecs++; if (cap_busy[n] !== (n <= l)) begin
          errs++; $display("FAIL rand%0d_busy[T%0d] got %b exp %b", f, n, cap_busy[n], n <= l);
        end
      end
      vecs++; if (sel_ch !== exp_sel || sgl !== exp_sgl) begin
        errs++; $display("FAIL rand%0d_cfg sel/sgl got %0d/%b exp %0d/%b", f, sel_ch, sgl, exp_sel, exp_sgl);
      end
    end
  endtask

  initial begin
    spi.cs = 1'b1;
    spi.din = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_fixed_frames();
    test_cs_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
